// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the voice allocator: note width, FSM encoding,
// tuning reference constants and the note-to-frequency-word helper used
// to fill the ROM at elaboration time.
package voice_allocator_pkg;

  localparam int NOTE_BITS = 7;
  localparam int REF_NOTE  = 69;     // A4
  localparam real REF_HZ   = 440.0;  // A4 pitch

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_ASSIGN = 2'd2
  } state_t;

  // Equal-tempered pitch converted to a phase increment, rounded to nearest
  // and clamped to the all-ones word of the given width.
  function automatic longint freq_word(input int note, input int acc_bits,
                                       input int sample_hz, input int freq_bits);
    real hz;
    real w;
    real lim;
    hz  = REF_HZ * (2.0 ** ((real'(note) - real'(REF_NOTE)) / 12.0));
    w   = $floor(hz * (2.0 ** acc_bits) / real'(sample_hz) + 0.5);
    lim = (2.0 ** freq_bits) - 1.0;
    if (w > lim) w = lim;
    return longint'(w);
  endfunction

endpackage

// File: rtl/note_freq_rom.sv
// 128-entry note-to-frequency-word ROM with a registered output.
// Latency: 1 cycle from note to freq. No flow control; reads every cycle.
// Contents are fixed at elaboration from the accumulator/sample-rate parameters.
module note_freq_rom
  import voice_allocator_pkg::*;
#(
  parameter int FREQ_BITS        = 16,
  parameter int ACCUMULATOR_BITS = 24,
  parameter int SAMPLE_CLK_FREQ  = 1000000
) (
  input  logic                 main_clk,
  input  logic                 rst,
  input  logic [NOTE_BITS-1:0] note,
  output logic [FREQ_BITS-1:0] freq
);

  logic [FREQ_BITS-1:0] rom_tbl [128];

  for (genvar n = 0; n < 128; n++) begin : g_rom
    localparam logic [FREQ_BITS-1:0] WORD =
      FREQ_BITS'(freq_word(n, ACCUMULATOR_BITS, SAMPLE_CLK_FREQ, FREQ_BITS));
    assign rom_tbl[n] = WORD;
  end

  // Registered read port
  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) freq <= '0;
    else     freq <= rom_tbl[note];
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto gated voices.
// Latency: outputs update on the 3rd edge counting the accept edge (IDLE->LOOKUP->ASSIGN).
// Backpressure: ev_ready high only in IDLE, so at most one event per 3 cycles.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES       = 4,
  parameter int FREQ_BITS        = 16,
  parameter int ACCUMULATOR_BITS = 24,
  parameter int SAMPLE_CLK_FREQ  = 1000000
) (
  input  logic                            main_clk,
  input  logic                            rst,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_note_on,
  input  logic [NOTE_BITS-1:0]            ev_note,
  input  logic [NUM_VOICES-1:0]           voice_idle,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [NUM_VOICES*FREQ_BITS-1:0] voice_freq
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [IW-1:0] OLDEST = IW'(NUM_VOICES - 1);

  state_t               state;
  logic                 cap_on;
  logic [NOTE_BITS-1:0] cap_note;
  logic [FREQ_BITS-1:0] rom_freq;
  logic [NOTE_BITS-1:0] vnote [NUM_VOICES];
  logic [IW-1:0]        rank  [NUM_VOICES];   // 0 = most recently started
  logic [FREQ_BITS-1:0] vfreq [NUM_VOICES];

  logic          same_hit, idle_hit, free_hit;
  logic [IW-1:0] same_idx, idle_idx, free_idx, old_idx, tgt;

  note_freq_rom #(
    .FREQ_BITS       (FREQ_BITS),
    .ACCUMULATOR_BITS(ACCUMULATOR_BITS),
    .SAMPLE_CLK_FREQ (SAMPLE_CLK_FREQ)
  ) u_rom (
    .main_clk(main_clk),
    .rst     (rst),
    .note    (cap_note),
    .freq    (rom_freq)
  );

  assign ev_ready = (state == ST_IDLE);

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_freq_out
    assign voice_freq[g*FREQ_BITS +: FREQ_BITS] = vfreq[g];
  end

  // Note-on target: retrigger same note, else idle free voice, else releasing voice, else steal oldest.
  // Scanning downward lets the lowest matching index win each category.
  always_comb begin
    same_hit = 1'b0;
    idle_hit = 1'b0;
    free_hit = 1'b0;
    same_idx = '0;
    idle_idx = '0;
    free_idx = '0;
    old_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voice_gate[i] && (vnote[i] == cap_note)) begin
        same_hit = 1'b1;
        same_idx = IW'(i);
      end
      if (!voice_gate[i] && voice_idle[i]) begin
        idle_hit = 1'b1;
        idle_idx = IW'(i);
      end
      if (!voice_gate[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
      if (rank[i] == OLDEST) old_idx = IW'(i);
    end
    tgt = old_idx;
    if (same_hit)      tgt = same_idx;
    else if (idle_hit) tgt = idle_idx;
    else if (free_hit) tgt = free_idx;
  end

  // Event FSM plus per-voice state update at the end of ASSIGN
  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cap_on     <= 1'b0;
      cap_note   <= '0;
      voice_gate <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vnote[i] <= '0;
        vfreq[i] <= '0;
        rank[i]  <= IW'(i);
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (ev_valid) begin
            cap_on   <= ev_note_on;
            cap_note <= ev_note;
            state    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: state <= ST_ASSIGN;
        ST_ASSIGN: begin
          state <= ST_IDLE;
          if (cap_on) begin
            // Gate is written high even on retrigger/steal, so it never dips.
            voice_gate[tgt] <= 1'b1;
            vfreq[tgt]      <= rom_freq;
            vnote[tgt]      <= cap_note;
            for (int j = 0; j < NUM_VOICES; j++) begin
              if (rank[j] < rank[tgt]) rank[j] <= rank[j] + 1'b1;
            end
            rank[tgt] <= '0;
          end else begin
            for (int j = 0; j < NUM_VOICES; j++) begin
              if (voice_gate[j] && (vnote[j] == cap_note)) voice_gate[j] <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
